// File: rtl/led_chaser.sv
// led_chaser: one-hot LED chaser driven by a periodic advance strobe.
// The lit position either bounces between LED 0 and LED N-1 or wraps
// from LED N-1 back to LED 0. All outputs are registered.
//
//   state | meaning
//   IDLE  | no LED lit, waiting for run
//   UP    | moves increment pos
//   DOWN  | moves decrement pos
module led_chaser #(
  parameter int N  = 16,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          run,
  input  logic          mode,
  output logic [N-1:0]  led,
  output logic [PW-1:0] pos,
  output logic          dir,
  output logic          end_tick
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  localparam logic [PW-1:0] LAST    = PW'(N - 1);
  localparam logic [PW-1:0] FIRST   = '0;
  localparam logic [N-1:0]  ONE_HOT = N'(1);

  state_t        state, state_nxt;
  logic [PW-1:0] pos_nxt;
  logic [N-1:0]  led_nxt;
  logic          dir_nxt;
  logic          end_nxt;
  logic          move;

  // Register state and all outputs; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= '0;
      led      <= '0;
      dir      <= 1'b0;
      end_tick <= 1'b0;
    end else begin
      state    <= state_nxt;
      pos      <= pos_nxt;
      led      <= led_nxt;
      dir      <= dir_nxt;
      end_tick <= end_nxt;
    end
  end

  // Next-state and next-output logic; a move needs run and tick while lit.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    move      = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_nxt = UP;
          pos_nxt   = FIRST;
        end
      end
      UP: begin
        if (run && tick) begin
          move = 1'b1;
          if (pos != LAST) begin
            pos_nxt = pos + 1'b1;
            if ((pos_nxt == LAST) && !mode) state_nxt = DOWN;
          end else if (mode) begin
            pos_nxt = FIRST;
          end else begin
            // Only reachable after switching from wrap to bounce at the top.
            pos_nxt   = LAST - 1'b1;
            state_nxt = (pos_nxt == FIRST) ? UP : DOWN;
          end
        end
      end
      DOWN: begin
        if (run && tick && (pos != FIRST)) begin
          move    = 1'b1;
          pos_nxt = pos - 1'b1;
          if (pos_nxt == FIRST) state_nxt = UP;
        end
      end
      default: begin
        state_nxt = IDLE;
        pos_nxt   = FIRST;
      end
    endcase
    end_nxt = move && ((pos_nxt == FIRST) || (pos_nxt == LAST));
    led_nxt = (state_nxt == IDLE) ? '0 : (ONE_HOT << pos_nxt);
    dir_nxt = (state_nxt == DOWN);
  end

endmodule

// File: tb/tb_led_chaser.sv
// Directed self-checking bench for led_chaser with N = 16.
module tb_led_chaser;

  logic        clk = 1'b0;
  logic        reset, tick, run, mode;
  logic [15:0] led;
  logic [3:0]  pos;
  logic        dir, end_tick;

  int errors = 0;
  int checks = 0;
  int end_cnt = 0;
  int base;

  led_chaser #(.N(16)) dut (
    .clk(clk), .reset(reset), .tick(tick), .run(run), .mode(mode),
    .led(led), .pos(pos), .dir(dir), .end_tick(end_tick)
  );

  always #5 clk = ~clk;

  // Count end_tick pulses, one per high cycle.
  always @(posedge clk) if (end_tick === 1'b1) end_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle tick with a low cycle before it; returns at the negedge after the move.
  task automatic tick_once();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; run = 1'b0; mode = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_pos", 32'(pos), 32'h0);
    chk("rst_dir", 32'(dir), 32'h0);
    chk("rst_end", 32'(end_tick), 32'h0);
    reset = 1'b0;

    // IDLE ignores ticks.
    base = end_cnt;
    ticks(5);
    @(negedge clk);
    chk("idle_led", 32'(led), 32'h0);
    chk("idle_pos", 32'(pos), 32'h0);
    chk("idle_end_cnt", 32'(end_cnt - base), 32'h0);

    // Start with a coincident tick, which must be ignored.
    base = end_cnt;
    run = 1'b1; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("start_led", 32'(led), 32'h0001);
    chk("start_end", 32'(end_tick), 32'h0);
    chk("start_dir", 32'(dir), 32'h0);

    ticks(14);
    chk("up14_led", 32'(led), 32'h4000);
    chk("up14_end", 32'(end_tick), 32'h0);
    tick_once();
    chk("top_led", 32'(led), 32'h8000);
    chk("top_pos", 32'(pos), 32'd15);
    chk("top_end", 32'(end_tick), 32'h1);
    chk("top_dir", 32'(dir), 32'h1);
    tick_once();
    chk("down1_led", 32'(led), 32'h4000);
    chk("down1_end", 32'(end_tick), 32'h0);
    chk("sweep_end_cnt", 32'(end_cnt - base), 32'd1);

    ticks(14);
    chk("bot_led", 32'(led), 32'h0001);
    chk("bot_end", 32'(end_tick), 32'h1);
    chk("bot_dir", 32'(dir), 32'h0);
    tick_once();
    chk("bot_next_led", 32'(led), 32'h0002);
    ticks(29);
    @(negedge clk);
    chk("sixty_led", 32'(led), 32'h0001);
    chk("sixty_end_cnt", 32'(end_cnt - base), 32'd4);

    // Wrap mode from pos 0 in UP.
    mode = 1'b1;
    ticks(15);
    chk("wrap_top_led", 32'(led), 32'h8000);
    chk("wrap_top_dir", 32'(dir), 32'h0);
    chk("wrap_top_end", 32'(end_tick), 32'h1);
    tick_once();
    chk("wrap_led", 32'(led), 32'h0001);
    chk("wrap_dir", 32'(dir), 32'h0);
    chk("wrap_end", 32'(end_tick), 32'h1);
    ticks(15);
    chk("wrap2_led", 32'(led), 32'h8000);
    mode = 1'b0;
    tick_once();
    chk("switch_led", 32'(led), 32'h4000);
    chk("switch_dir", 32'(dir), 32'h1);
    chk("switch_end", 32'(end_tick), 32'h0);

    // Freeze while moving down at pos 5.
    ticks(9);
    chk("frz_dn_led", 32'(led), 32'h0020);
    run = 1'b0;
    base = end_cnt;
    ticks(10);
    @(negedge clk);
    chk("frz_dn_hold", 32'(led), 32'h0020);
    chk("frz_dn_end_cnt", 32'(end_cnt - base), 32'h0);
    run = 1'b1;
    tick_once();
    chk("unfrz_dn_led", 32'(led), 32'h0010);
    chk("unfrz_dn_dir", 32'(dir), 32'h1);

    // Freeze while moving up at pos 5.
    ticks(9);
    chk("frz_up_led", 32'(led), 32'h0020);
    chk("frz_up_dir", 32'(dir), 32'h0);
    run = 1'b0;
    ticks(3);
    chk("frz_up_hold", 32'(led), 32'h0020);
    run = 1'b1;
    tick_once();
    chk("unfrz_up_led", 32'(led), 32'h0040);

    // Reset coincident with tick mid-run.
    ticks(4);
    chk("pre_rst_led", 32'(led), 32'h0400);
    @(negedge clk);
    reset = 1'b1; tick = 1'b1;
    @(negedge clk);
    reset = 1'b0; tick = 1'b0;
    chk("midrst_led", 32'(led), 32'h0);
    chk("midrst_pos", 32'(pos), 32'h0);
    chk("midrst_dir", 32'(dir), 32'h0);
    @(negedge clk);
    chk("restart_led", 32'(led), 32'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
